// File: rtl/pipe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_pkg: stage state encoding and per-boundary bubble payloads        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } stage_state_e;

   // ID/EX payload; a bubble must carry branch_sel=3'b010 ("no branch").
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic [2:0]  branch_sel;
   } idex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
   } exmem_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd;
      logic        reg_we;
   } memwb_t;

   localparam int IDEX_W  = $bits(idex_t);
   localparam int EXMEM_W = $bits(exmem_t);
   localparam int MEMWB_W = $bits(memwb_t);

   localparam idex_t IDEX_BUBBLE_S = '{
      pc: 32'd0, op_a: 32'd0, op_b: 32'd0, rd: 5'd0, alu_op: 4'd0,
      reg_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0, branch_sel: 3'b010
   };
   localparam exmem_t EXMEM_BUBBLE_S = '{
      alu_res: 32'd0, store_data: 32'd0, rd: 5'd0,
      reg_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0
   };
   localparam memwb_t MEMWB_BUBBLE_S = '{
      wb_data: 32'd0, rd: 5'd0, reg_we: 1'b0
   };

   localparam logic [IDEX_W-1:0]  IDEX_BUBBLE  = IDEX_BUBBLE_S;
   localparam logic [EXMEM_W-1:0] EXMEM_BUBBLE = EXMEM_BUBBLE_S;
   localparam logic [MEMWB_W-1:0] MEMWB_BUBBLE = MEMWB_BUBBLE_S;

   function automatic logic [1:0] state_count(input stage_state_e s);
      case (s)
         ST_FULL: return 2'd1;
         ST_SKID: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_stage_skid_reg: valid/ready pipeline register, optional skid slot |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int              DATA_W     = 32,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
   parameter bit              SKID_EN    = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              hold_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        count_o
);

   stage_state_e      state;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] skid_data;
   logic              in_xfer;
   logic              out_xfer;

   // hold_i gates both handshakes, so a frozen stage never transfers.
   assign valid_o  = (state != ST_EMPTY) & ~hold_i;
   assign in_xfer  = valid_i & ready_o;
   assign out_xfer = valid_o & ready_i;

   // main_data is parked at BUBBLE_VAL whenever the stage is empty.
   assign data_o  = main_data;
   assign count_o = state_count(state);

   generate
      if (SKID_EN) begin : g_skid
         assign ready_o = (state != ST_SKID) & ~hold_i;
      end else begin : g_single
         assign ready_o = (ready_i | (state == ST_EMPTY)) & ~hold_i;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         state     <= ST_EMPTY;
         main_data <= BUBBLE_VAL;
         skid_data <= {DATA_W{1'b0}};
      end else if (!hold_i) begin
         case (state)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_data <= data_i;
                  state     <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (in_xfer && out_xfer) begin
                  main_data <= data_i;
               end else if (out_xfer) begin
                  main_data <= BUBBLE_VAL;
                  state     <= ST_EMPTY;
               end else if (in_xfer && SKID_EN) begin
                  skid_data <= data_i;
                  state     <= ST_SKID;
               end
            end
            ST_SKID: begin
               if (out_xfer) begin
                  main_data <= skid_data;
                  skid_data <= {DATA_W{1'b0}};
                  state     <= ST_FULL;
               end
            end
            default: begin
               main_data <= BUBBLE_VAL;
               skid_data <= {DATA_W{1'b0}};
               state     <= ST_EMPTY;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// Bench for pipe_stage_skid_reg: directed vector table on the skid variant,
// plus a queue-based reference model checking both variants every cycle.
module tb_pipe_stage_skid_reg;
   import pipe_pkg::*;

   localparam int W = IDEX_W;
   localparam logic [W-1:0] BUB = IDEX_BUBBLE;

   logic         clk = 1'b0;
   logic         rst, flush, hold, valid, ready;
   logic [W-1:0] data;

   logic         s_ready, s_valid, f_ready, f_valid;
   logic [W-1:0] s_data, f_data;
   logic [1:0]   s_count, f_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] q_s[$];
   logic [W-1:0] q_f[$];

   typedef struct {
      bit           rst, flush, hold, valid, ready;
      logic [W-1:0] data;
      bit           e_valid, e_ready;
      logic [W-1:0] e_data;
      logic [1:0]   e_count;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   pipe_stage_skid_reg #(.DATA_W(W), .BUBBLE_VAL(BUB), .SKID_EN(1'b1)) dut_skid (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .hold_i(hold),
      .valid_i(valid), .ready_o(s_ready), .data_i(data),
      .valid_o(s_valid), .ready_i(ready), .data_o(s_data), .count_o(s_count)
   );

   pipe_stage_skid_reg #(.DATA_W(W), .BUBBLE_VAL(BUB), .SKID_EN(1'b0)) dut_flow (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .hold_i(hold),
      .valid_i(valid), .ready_o(f_ready), .data_i(data),
      .valid_o(f_valid), .ready_i(ready), .data_o(f_data), .count_o(f_count)
   );

   function automatic logic [W-1:0] v8(input logic [7:0] b);
      return W'(b);
   endfunction

   function automatic vec_t row(input bit r, f, h, v, input logic [7:0] d, input bit rd,
                                input bit ev, er, input logic [W-1:0] ed, input logic [1:0] ec);
      vec_t x;
      x.rst = r; x.flush = f; x.hold = h; x.valid = v; x.data = v8(d); x.ready = rd;
      x.e_valid = ev; x.e_ready = er; x.e_data = ed; x.e_count = ec;
      return x;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model's view of the stage: a FIFO of held payloads, capacity 2 or 1.
   function automatic bit m_ready(input int sz, input bit skid_en);
      if (hold) return 1'b0;
      return skid_en ? (sz < 2) : (sz == 0 || ready);
   endfunction

   task automatic model_check();
      chk("skid.valid", 128'(s_valid), 128'(q_s.size() > 0 && !hold));
      chk("skid.ready", 128'(s_ready), 128'(m_ready(q_s.size(), 1'b1)));
      chk("skid.count", 128'(s_count), 128'(q_s.size()));
      chk("skid.data",  128'(s_data),  128'(q_s.size() > 0 ? q_s[0] : BUB));
      chk("flow.valid", 128'(f_valid), 128'(q_f.size() > 0 && !hold));
      chk("flow.ready", 128'(f_ready), 128'(m_ready(q_f.size(), 1'b0)));
      chk("flow.count", 128'(f_count), 128'(q_f.size()));
      chk("flow.data",  128'(f_data),  128'(q_f.size() > 0 ? q_f[0] : BUB));
   endtask

   task automatic apply(input bit r, f, h, v, input logic [W-1:0] d, input bit rd);
      @(negedge clk);
      rst = r; flush = f; hold = h; valid = v; data = d; ready = rd;
      #1;
      model_check();
   endtask

   task automatic tick();
      bit s_pop, s_push, f_pop, f_push;
      s_pop  = (q_s.size() > 0) && !hold && ready;
      s_push = valid && m_ready(q_s.size(), 1'b1);
      f_pop  = (q_f.size() > 0) && !hold && ready;
      f_push = valid && m_ready(q_f.size(), 1'b0);
      @(posedge clk);
      if (rst || flush) begin
         q_s.delete();
         q_f.delete();
      end else begin
         if (s_pop) void'(q_s.pop_front());
         if (s_push) q_s.push_back(data);
         if (f_pop) void'(q_f.pop_front());
         if (f_push) q_f.push_back(data);
      end
   endtask

   initial begin
      logic [127:0] rnd;
      rst = 1'b1; flush = 1'b0; hold = 1'b0; valid = 1'b0; ready = 1'b0; data = '0;
      repeat (2) @(posedge clk);

      // rst flush hold valid data ready | valid ready data count (before edge)
      tbl.push_back(row(0,0,0,1,8'h11,1, 0,1,BUB,2'd0));
      tbl.push_back(row(0,0,0,1,8'h22,1, 1,1,v8(8'h11),2'd1));
      tbl.push_back(row(0,0,0,1,8'h33,1, 1,1,v8(8'h22),2'd1));
      tbl.push_back(row(0,0,0,1,8'hA5,1, 1,1,v8(8'h33),2'd1));
      tbl.push_back(row(0,0,0,1,8'h5A,0, 1,1,v8(8'hA5),2'd1));
      tbl.push_back(row(0,0,0,1,8'h99,0, 1,0,v8(8'hA5),2'd2));
      tbl.push_back(row(0,0,0,0,8'h00,1, 1,0,v8(8'hA5),2'd2));
      tbl.push_back(row(0,0,0,0,8'h00,1, 1,1,v8(8'h5A),2'd1));
      tbl.push_back(row(0,0,0,0,8'h00,0, 0,1,BUB,2'd0));
      tbl.push_back(row(0,0,0,1,8'h01,0, 0,1,BUB,2'd0));
      tbl.push_back(row(0,0,0,1,8'h02,0, 1,1,v8(8'h01),2'd1));
      tbl.push_back(row(0,1,0,1,8'h77,1, 1,0,v8(8'h01),2'd2));
      tbl.push_back(row(0,0,0,0,8'h00,0, 0,1,BUB,2'd0));
      tbl.push_back(row(0,0,0,1,8'h3C,0, 0,1,BUB,2'd0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(row(0,0,1,1,8'h44,1, 0,0,v8(8'h3C),2'd1));
      tbl.push_back(row(0,0,0,0,8'h00,1, 1,1,v8(8'h3C),2'd1));
      tbl.push_back(row(0,0,0,0,8'h00,1, 0,1,BUB,2'd0));
      tbl.push_back(row(0,0,0,1,8'h0A,0, 0,1,BUB,2'd0));
      tbl.push_back(row(0,0,0,1,8'h0B,0, 1,1,v8(8'h0A),2'd1));
      tbl.push_back(row(1,1,1,1,8'h0C,1, 0,0,v8(8'h0A),2'd2));
      tbl.push_back(row(0,0,0,0,8'h00,0, 0,1,BUB,2'd0));

      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].flush, tbl[i].hold, tbl[i].valid, tbl[i].data, tbl[i].ready);
         chk($sformatf("vec%0d.valid", i), 128'(s_valid), 128'(tbl[i].e_valid));
         chk($sformatf("vec%0d.ready", i), 128'(s_ready), 128'(tbl[i].e_ready));
         chk($sformatf("vec%0d.data", i),  128'(s_data),  128'(tbl[i].e_data));
         chk($sformatf("vec%0d.count", i), 128'(s_count), 128'(tbl[i].e_count));
         tick();
      end

      // Single-entry variant: ready_o follows ready_i within the cycle.
      apply(0,0,0,1,v8(8'hC1),0);
      chk("flow.empty_ready", 128'(f_ready), 128'(1'b1));
      tick();
      apply(0,0,0,1,v8(8'hC2),0);
      chk("flow.full_blocked", 128'(f_ready), 128'(1'b0));
      chk("flow.hold_c1", 128'(f_data), 128'(v8(8'hC1)));
      tick();
      apply(0,0,0,1,v8(8'hC2),1);
      chk("flow.pass_ready", 128'(f_ready), 128'(1'b1));
      tick();
      apply(0,0,0,1,v8(8'hC3),1);
      chk("flow.pass_c2", 128'(f_data), 128'(v8(8'hC2)));
      tick();
      apply(0,0,0,1,v8(8'hC4),1);
      chk("flow.pass_c3", 128'(f_data), 128'(v8(8'hC3)));
      tick();
      apply(0,0,0,0,v8(8'h00),1);
      chk("flow.pass_c4", 128'(f_data), 128'(v8(8'hC4)));
      tick();

      for (int i = 0; i < 800; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         apply($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7,
               rnd[W-1:0], $urandom_range(0, 9) < 6);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid_reg.md
PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (1..512).
REQ-002 SHALL have parameter BUBBLE_VAL, default {DATA_W{1'b0}}, payload driven on data_o when no valid entry (e.g. ID/EX bubble with branch_sel=3'b010).
REQ-003 SHALL have parameter SKID_EN, default 1, 1 = two-entry skid (registered ready_o), 0 = single entry (combinational ready_o).
REQ-004 SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush_i  input  1  synchronous kill of all held entries.
REQ-007 SHALL have port hold_i  input  1  global freeze (memory busywait).
REQ-008 SHALL have port valid_i  input  1  upstream payload valid.
REQ-009 SHALL have port ready_o  output  1  stage can accept payload.
REQ-010 SHALL have port data_i  input  DATA_W  upstream payload.
REQ-011 SHALL have port valid_o  output  1  downstream payload valid.
REQ-012 SHALL have port ready_i  input  1  downstream accepts payload.
REQ-013 SHALL have port data_o  output  DATA_W  downstream payload.
REQ-014 SHALL have port count_o  output  2  entries held (0..2).

Function
REQ-015 SHALL define an input transfer as valid_i & ready_o and an output transfer as valid_o & ready_i, both sampled at the rising edge.
REQ-016 SHALL hold state EMPTY, FULL (main entry valid) or SKID (main + skid valid; reachable only when SKID_EN=1).
REQ-017 SHALL, EMPTY + input transfer: capture data_i into main, go FULL; latency data_i to data_o is exactly 1 cycle.
REQ-018 SHALL, FULL + input and output transfer: replace main with data_i, stay FULL (full throughput, 1 transfer/cycle).
REQ-019 SHALL, FULL + output transfer only: go EMPTY.
REQ-020 SHALL, FULL + input transfer only (SKID_EN=1): store data_i in skid, go SKID.
REQ-021 SHALL, SKID + output transfer: move skid into main, go FULL; no input accepted in SKID.
REQ-022 SHALL preserve strict FIFO order; no payload dropped or duplicated except by flush_i/rst_i.
REQ-023 SHALL drive ready_o (SKID_EN=1) from registered state only: ready_o = (state != SKID) & !hold_i.
REQ-024 SHALL drive ready_o (SKID_EN=0) as (ready_i | state==EMPTY) & !hold_i.
REQ-025 SHALL drive valid_o = (state != EMPTY) & !hold_i; data_o = main when state != EMPTY, else BUBBLE_VAL.
REQ-026 SHALL, while hold_i=1, change no state and no stored payload; data_o keeps its value.
REQ-027 SHALL, on flush_i=1, go EMPTY next cycle regardless of hold_i, valid_i or ready_i; a same-cycle input payload is discarded.
REQ-028 SHALL drive count_o = 0/1/2 for EMPTY/FULL/SKID.

Reset
REQ-029 SHALL, with rst_i=1 at a rising edge, go EMPTY: valid_o=0, count_o=0, data_o=BUBBLE_VAL, skid cleared; rst_i overrides flush_i and hold_i.
REQ-030 SHALL reset mid-operation (FULL or SKID) with all held payloads discarded and no output transfer counted in that cycle.
REQ-031 SHALL contain no asynchronous logic, no delay statements and no latches.

Structure
REQ-032 SHALL take the state encoding and per-boundary BUBBLE_VAL constants (ID/EX, EX/MEM, MEM/WB) from shared package pipe_pkg.
REQ-033 SHALL be a single flat module without sub-modules; each pipeline boundary instantiates it with its packed payload width.

Verification
REQ-034 SHALL: reset, then valid_i=1 with data_i=0x11,0x22,0x33 on consecutive cycles, ready_i=1 -> data_o 0x11,0x22,0x33 one cycle later each, count_o=1 throughout.
REQ-035 SHALL: SKID_EN=1, FULL with 0xA5, ready_i=0, valid_i=1 data_i=0x5A -> count_o=2, ready_o=0; ready_i=1 -> data_o 0xA5 then 0x5A.
REQ-036 SHALL: count_o=2, flush_i=1 with valid_i=1 data_i=0x77 -> next cycle count_o=0, valid_o=0, data_o=BUBBLE_VAL; 0x77 never appears.
REQ-037 SHALL: FULL with 0x3C, hold_i=1 for 5 cycles, valid_i=1, ready_i=1 -> ready_o=0, valid_o=0, data_o=0x3C, count_o=1 unchanged; release -> 0x3C transferred once.
REQ-038 SHALL: SKID_EN=0, FULL, ready_i=0 -> ready_o=0 same cycle; ready_i=1 with valid_i=1 -> pass-through at 1 per cycle.
REQ-039 SHALL: rst_i=1 together with flush_i=1 and hold_i=1 in SKID -> next cycle count_o=0, data_o=BUBBLE_VAL (e.g. branch_sel field 3'b010).
